// File: rtl/ir_motor_ctrl.sv
// IR command byte to dual DC motor drive: input qualification, key decode,
// direction sequencing (run / brake ramp / dead time) and PWM generation.
module ir_motor_ctrl #(
  parameter int STABLE_CYCLES = 1024,
  parameter int RAMP_DIV      = 20000,
  parameter int PWM_DIV       = 4,
  parameter int DEAD_CYCLES   = 100000
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic [7:0] frame_db,
  output logic       cmd_valid,
  output logic       motor_l_in1,
  output logic       motor_l_in2,
  output logic       motor_r_in1,
  output logic       motor_r_in2,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic [1:0] state,
  output logic [1:0] speed_level
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int RW = $clog2(RAMP_DIV + 1);
  localparam int PW = $clog2(PWM_DIV + 1);
  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);
  localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_DIV - 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_BRAKE = 2'd2, S_DEAD = 2'd3} state_e;
  typedef enum logic [2:0] {K_NONE, K_FWD, K_REV, K_LEFT, K_RIGHT, K_STOP} key_e;

  function automatic key_e decode_key(input logic [7:0] b);
    case (b)
      8'h18:   return K_FWD;
      8'h52:   return K_REV;
      8'h08:   return K_LEFT;
      8'h5A:   return K_RIGHT;
      8'h1C:   return K_STOP;
      default: return K_NONE;
    endcase
  endfunction

  // {l_in1, l_in2, r_in1, r_in2}
  function automatic logic [3:0] pins_of(input key_e k);
    case (k)
      K_FWD:   return 4'b1010;
      K_REV:   return 4'b0101;
      K_LEFT:  return 4'b0110;
      K_RIGHT: return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [7:0] level_duty(input logic [1:0] lvl);
    case (lvl)
      2'd0:    return 8'd64;
      2'd1:    return 8'd128;
      2'd2:    return 8'd192;
      default: return 8'd255;
    endcase
  endfunction

  function automatic logic [1:0] sat_level(input logic [1:0] lvl, input logic up, input logic dn);
    if (up && lvl != 2'd3) return lvl + 2'd1;
    if (dn && lvl != 2'd0) return lvl - 2'd1;
    return lvl;
  endfunction

  logic [7:0]    sync1_q, sync2_q, cand_q, acc_q, acc_d;
  logic [SW-1:0] stab_q, stab_d;
  logic          cmd_valid_q, cmd_valid_d;
  state_e        state_q, state_d;
  key_e          dir_cur_q, dir_cur_d, dir_pend_q, dir_pend_d;
  logic [DW-1:0] dead_q, dead_d;
  logic [1:0]    speed_q, speed_d;
  logic [7:0]    duty_q, duty_d;
  logic [RW-1:0] ramp_q, ramp_d;
  logic [PW-1:0] pdiv_q, pdiv_d;
  logic [7:0]    pcnt_q, pcnt_d;
  logic [3:0]    pins;

  key_e       cmd_key, pend_nxt;
  logic       is_motion, is_stop, ramp_tick, pwm_tick;
  logic [7:0] target;

  // stab_q is the run length of the value cand_q held; acceptance needs sync2_q to extend it
  always_comb begin
    stab_d      = (sync2_q != cand_q) ? SW'(1) : ((stab_q == '1) ? stab_q : stab_q + SW'(1));
    cmd_valid_d = (sync2_q == cand_q) && (stab_q >= STAB_LAST) && (sync2_q != acc_q);
    acc_d       = cmd_valid_d ? sync2_q : acc_q;
  end

  always_comb begin
    cmd_key    = cmd_valid_q ? decode_key(acc_q) : K_NONE;
    is_motion  = (cmd_key == K_FWD) || (cmd_key == K_REV) || (cmd_key == K_LEFT) || (cmd_key == K_RIGHT);
    is_stop    = (cmd_key == K_STOP);
    pend_nxt   = (is_motion || is_stop) ? cmd_key : dir_pend_q;
    state_d    = state_q;
    dir_cur_d  = dir_cur_q;
    dir_pend_d = dir_pend_q;
    dead_d     = dead_q;
    case (state_q)
      S_IDLE: if (is_motion) begin
        dir_cur_d = cmd_key;
        state_d   = S_RUN;
      end
      S_RUN: if ((is_motion && cmd_key != dir_cur_q) || is_stop) begin
        dir_pend_d = cmd_key;
        state_d    = S_BRAKE;
      end
      S_BRAKE: begin
        dir_pend_d = pend_nxt;
        if (duty_q == 8'd0) begin
          state_d = S_DEAD;
          dead_d  = DEAD_LAST;
        end
      end
      S_DEAD: begin
        dir_pend_d = pend_nxt;
        if (dead_q == '0) begin
          // a command landing on the expiry cycle still counts as the latest
          if (pend_nxt == K_STOP) state_d = S_IDLE;
          else begin
            dir_cur_d = pend_nxt;
            state_d   = S_RUN;
          end
        end else begin
          dead_d = dead_q - DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    speed_d   = sat_level(speed_q, cmd_valid_q && acc_q == 8'h46, cmd_valid_q && acc_q == 8'h15);
    ramp_tick = (ramp_q == RAMP_LAST);
    ramp_d    = ramp_tick ? '0 : ramp_q + RW'(1);
    target    = (state_q == S_RUN) ? level_duty(speed_q) : 8'd0;
    duty_d    = duty_q;
    if (ramp_tick && duty_q < target) duty_d = duty_q + 8'd1;
    else if (ramp_tick && duty_q > target) duty_d = duty_q - 8'd1;
    pwm_tick  = (pdiv_q == PWM_LAST);
    pdiv_d    = pwm_tick ? '0 : pdiv_q + PW'(1);
    pcnt_d    = pcnt_q;
    if (pwm_tick) pcnt_d = (pcnt_q == 8'd254) ? 8'd0 : pcnt_q + 8'd1;
    pins      = 4'b0000;
    if (state_q == S_RUN || state_q == S_BRAKE) pins = pins_of(dir_cur_q);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 8'h00;
      sync2_q     <= 8'h00;
      cand_q      <= 8'h00;
      stab_q      <= '0;
      acc_q       <= 8'h00;
      cmd_valid_q <= 1'b0;
      state_q     <= S_IDLE;
      dir_cur_q   <= K_NONE;
      dir_pend_q  <= K_NONE;
      dead_q      <= '0;
      speed_q     <= 2'd1;
      duty_q      <= 8'd0;
      ramp_q      <= '0;
      pdiv_q      <= '0;
      pcnt_q      <= 8'd0;
    end else begin
      sync1_q     <= frame_db;
      sync2_q     <= sync1_q;
      cand_q      <= sync2_q;
      stab_q      <= stab_d;
      acc_q       <= acc_d;
      cmd_valid_q <= cmd_valid_d;
      state_q     <= state_d;
      dir_cur_q   <= dir_cur_d;
      dir_pend_q  <= dir_pend_d;
      dead_q      <= dead_d;
      speed_q     <= speed_d;
      duty_q      <= duty_d;
      ramp_q      <= ramp_d;
      pdiv_q      <= pdiv_d;
      pcnt_q      <= pcnt_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign state       = state_q;
  assign speed_level = speed_q;
  assign {motor_l_in1, motor_l_in2, motor_r_in1, motor_r_in2} = pins;
  assign pwm_l       = (pcnt_q < duty_q);
  assign pwm_r       = (pcnt_q < duty_q);

endmodule

// File: doc/ir_motor_ctrl.md
# ir_motor_ctrl

Consumes the 8-bit NEC command byte produced by the IR receiver and turns it into drive signals for the miniCar's two DC motors (H-bridge direction pins plus PWM enables). It resynchronises and qualifies the byte, decodes key codes into motion and speed commands, and sequences direction changes through a ramp-down and dead-time so the H-bridge is never reversed under load. It sits between the IR receiver and the motor driver pins.

## Interface
- STABLE_CYCLES, 1024: consecutive cycles a new byte must hold before acceptance
- RAMP_DIV, 20000: clk_in cycles per ±1 duty step
- PWM_DIV, 4: clk_in cycles per PWM counter increment
- DEAD_CYCLES, 100000: cycles with all direction pins low between directions
- clk_in  in  1  system clock (100 MHz)
- rst_n  in  1  asynchronous, active-low reset
- frame_db  in  8  command byte from the IR receiver; asynchronous to clk_in; level, no strobe
- cmd_valid  out  1  one-cycle pulse when a new byte is accepted
- motor_l_in1, motor_l_in2  out  1 each  left H-bridge direction
- motor_r_in1, motor_r_in2  out  1 each  right H-bridge direction
- pwm_l, pwm_r  out  1 each  motor enables (identical waveform)
- state  out  2  FSM state: 0 IDLE, 1 RUN, 2 BRAKE, 3 DEAD
- speed_level  out  2  current speed level

## Operation
- Input: frame_db goes through a 2-flop synchroniser. A candidate counter resets whenever the synchronised value changes. When it differs from the last accepted byte (reset 0x00) and has been stable for STABLE_CYCLES cycles, it is accepted and cmd_valid pulses. A repeated press of the same key produces no new event; this is accepted behaviour.
- Key codes: 0x18 FWD, 0x52 REV, 0x08 LEFT, 0x5A RIGHT, 0x1C STOP, 0x46 SPEED_UP, 0x15 SPEED_DOWN. All other codes are accepted (cmd_valid pulses) and ignored.
- Pin patterns (in1,in2):
  - FWD: L=10, R=10
  - REV: L=01, R=01
  - LEFT: L=01, R=10
  - RIGHT: L=10, R=01
  - IDLE/BRAKE-end/DEAD: all 00
- Speed: speed_level resets to 1. SPEED_UP and SPEED_DOWN saturate at 3 and 0 and are honoured in every state. The level maps to a target duty: 0→64, 1→128, 2→192, 3→255.
- Ramp: on each RAMP_DIV tick, duty (8-bit, reset 0) moves ±1 toward the ramp target. The ramp target is the level duty in RUN and 0 in all other states.
- PWM: the counter advances every PWM_DIV cycles, counting 0..254 and wrapping. pwm = (cnt < duty). Duty 255 gives constant high; duty 0 gives constant low.
- FSM:
  - IDLE: on a motion key, dir_cur <= key and go to RUN. STOP is ignored.
  - RUN: pins follow dir_cur. A motion key equal to dir_cur does nothing. A different motion key or STOP sets dir_pending <= key and goes to BRAKE.
  - BRAKE: pins stay at dir_cur while duty ramps to 0. When duty==0, go to DEAD and load the dead counter.
  - DEAD: pins 00, duty 0, counter runs DEAD_CYCLES. At expiry: if dir_pending==STOP go to IDLE, otherwise dir_cur <= dir_pending and go to RUN.
  - Commands arriving in BRAKE or DEAD overwrite dir_pending; the last one wins. A motion key equal to dir_cur received in BRAKE is still treated as pending, and the full dead time is still served.

## Timing
- Reset values:
  - cmd_valid=0, state=IDLE, speed_level=1, duty=0, all pins 0, pwm 0
  - synchroniser, stability counter, ramp/PWM/dead counters 0
  - accepted byte 0x00
- Acceptance latency: cmd_valid rises STABLE_CYCLES+2 cycles after frame_db changes, provided frame_db stays stable that long.
- The FSM samples the decoded command on the cmd_valid cycle. state and pins update on the next edge.
- Speed change takes effect on the edge after cmd_valid. duty then reaches the new target after |Δ|·RAMP_DIV cycles.
- A glitch shorter than STABLE_CYCLES never produces cmd_valid.
- Asserting rst_n low mid-ramp or mid-dead-time forces all outputs to their reset values immediately, asynchronously.

## Test plan
Parameters for all scenarios: STABLE_CYCLES=4, RAMP_DIV=2, PWM_DIV=1, DEAD_CYCLES=8.
- Reset, then frame_db=0x18 held -> cmd_valid one pulse at cycle 6; state=RUN; pins L=10, R=10; duty reaches 128 after 256 cycles; pwm high 128 of every 255 counts.
- From RUN FWD at duty 128, frame_db=0x52 -> BRAKE with pins still 10 until duty=0 (~256 cycles); DEAD with pins 00 for 8 cycles; RUN with pins 01; duty ramps back up to 128.
- frame_db toggles 0x18→0x5A for 3 cycles then back to 0x18 -> no cmd_valid, no state change.
- IDLE, sequence 0x46, 0x15, 0x46, 0x46-via-0x00-between -> speed_level 1→2→1→2→3; three further 0x46/0x00 pairs keep it saturated at 3; duty target 255 gives constant pwm high.
- RUN LEFT, send 0x1C then 0x5A during BRAKE -> after DEAD goes to RUN RIGHT (L=10, R=01), not IDLE.
- rst_n low for 1 cycle during DEAD -> all outputs return to their reset values immediately; the next 0x18 behaves as in the first scenario.
